// File: rtl/cp0_unit.sv
// cp0_unit: CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC), exception/ERET redirect
// and registered interrupt request. The Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_unit #(
    parameter int          HW_INT_N   = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] INT_VECTOR = 32'hBFC0_0400
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic                we,
    input  logic                re,
    input  logic [4:0]          waddr,
    input  logic [4:0]          raddr,
    input  logic [31:0]         wdata,
    input  logic [HW_INT_N-1:0] int_i,
    input  logic [4:0]          exccode_i,
    input  logic [31:0]         exc_badvaddr_i,
    input  logic [31:0]         pc_i,
    input  logic                in_delay_i,
    output logic                flush,
    output logic                flush_im,
    output logic [31:0]         cp0_excaddr,
    output logic [31:0]         data_o,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic                int_req_o
);

    localparam logic [4:0]  EXC_INT      = 5'h00;
    localparam logic [4:0]  EXC_NONE     = 5'h10;
    localparam logic [4:0]  EXC_ERET     = 5'h11;
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] status_q, status_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic [5:0]  hw_ip_q, hw_ip_d;
    logic        flush_im_q;
    logic        int_req_q, int_req_d;
    logic        is_exc_s, is_eret_s, mtc0_s;
    logic [31:0] count_s, compare_s, cause_s;
    logic        ti_s;

    assign is_exc_s  = (exccode_i != EXC_NONE) && (exccode_i != EXC_ERET);
    assign is_eret_s = (exccode_i == EXC_ERET);
    assign mtc0_s    = we && (exccode_i == EXC_NONE);

    // Zero-extend the hardware lines into the six IP[15:10] slots.
    always_comb begin
        hw_ip_d = 6'd0;
        for (int i = 0; i < HW_INT_N; i++) begin
            hw_ip_d[i] = int_i[i];
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d, count_inc_s;
    logic        phase_q, phase_d, ti_q, ti_d;

    // Count advances every second cycle; a Count write restarts the phase and a Compare write clears TI.
    always_comb begin
        count_inc_s = count_q + 32'd1;
        phase_d     = ~phase_q;
        count_d     = count_q;
        compare_d   = compare_q;
        ti_d        = ti_q;
        if (mtc0_s && (waddr == REG_COUNT)) begin
            count_d = wdata;
            phase_d = 1'b0;
        end else if (phase_q) begin
            count_d = count_inc_s;
            ti_d    = ti_q | (count_inc_s == compare_q);
        end else begin
            count_d = count_q;
        end
        if (mtc0_s && (waddr == REG_COMPARE)) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else begin
            compare_d = compare_q;
        end
    end

    // Timer state register.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            phase_q   <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            phase_q   <= phase_d;
            ti_q      <= ti_d;
        end
    end

    assign count_s   = count_q;
    assign compare_s = compare_q;
    assign ti_s      = ti_q;
`else
    assign count_s   = 32'd0;
    assign compare_s = 32'd0;
    assign ti_s      = 1'b0;
`endif

    // TI shares IP[15] with the sixth hardware line.
    assign cause_s   = {bd_q, ti_s, 14'd0, hw_ip_q[5] | ti_s, hw_ip_q[4:0], sw_ip_q, 1'b0, exccode_q, 2'b00};
    assign int_req_d = status_q[0] & ~status_q[1] & (|(cause_s[15:8] & status_q[15:8]));

    // Architectural next state: exception beats ERET beats mtc0.
    always_comb begin
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        status_d   = status_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        sw_ip_d    = sw_ip_q;
        if (is_exc_s) begin
            if (!status_q[1]) begin
                epc_d = in_delay_i ? (pc_i - 32'd4) : pc_i;
                bd_d  = in_delay_i;
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            status_d[1] = 1'b1;
            exccode_d   = exccode_i;
            badvaddr_d  = exc_badvaddr_i;
        end else if (is_eret_s) begin
            status_d[1] = 1'b0;
        end else if (mtc0_s) begin
            case (waddr)
                REG_STATUS: status_d = wdata & STATUS_WMASK;
                REG_CAUSE:  sw_ip_d  = wdata[9:8];
                REG_EPC:    epc_d    = wdata;
                default:    epc_d    = epc_q;
            endcase
        end else begin
            sw_ip_d = sw_ip_q;
        end
    end

    // Architectural register file, interrupt sample and request, delayed flush.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            badvaddr_q <= 32'd0;
            epc_q      <= 32'd0;
            status_q   <= STATUS_RESET;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            sw_ip_q    <= 2'd0;
            hw_ip_q    <= 6'd0;
            flush_im_q <= 1'b0;
            int_req_q  <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            status_q   <= status_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            sw_ip_q    <= sw_ip_d;
            hw_ip_q    <= hw_ip_d;
            flush_im_q <= flush;
            int_req_q  <= int_req_d;
        end
    end

    // Redirect target, flush and mfc0 data; reads return the pre-write value.
    always_comb begin
        flush       = 1'b0;
        cp0_excaddr = 32'd0;
        data_o      = 32'd0;
        if (cpu_rst_n) begin
            flush = (exccode_i != EXC_NONE);
            case (exccode_i)
                EXC_NONE: cp0_excaddr = 32'd0;
                EXC_INT:  cp0_excaddr = INT_VECTOR;
                EXC_ERET: cp0_excaddr = (we && (waddr == REG_EPC)) ? wdata : epc_q;
                default:  cp0_excaddr = EXC_VECTOR;
            endcase
            if (re) begin
                case (raddr)
                    REG_BADVADDR: data_o = badvaddr_q;
                    REG_COUNT:    data_o = count_s;
                    REG_COMPARE:  data_o = compare_s;
                    REG_STATUS:   data_o = status_q;
                    REG_CAUSE:    data_o = cause_s;
                    REG_EPC:      data_o = epc_q;
                    default:      data_o = 32'd0;
                endcase
            end else begin
                data_o = 32'd0;
            end
        end else begin
            flush = 1'b0;
        end
    end

    assign flush_im  = flush_im_q;
    assign status_o  = status_q;
    assign cause_o   = cause_s;
    assign int_req_o = int_req_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: directed scenarios plus a randomized run checked against a cycle model.
module tb_cp0_unit;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;
`ifdef CP0_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, re = 1'b0, in_delay = 1'b0;
    logic [4:0]  waddr = 5'd0, raddr = 5'd0, exccode = EXC_NONE;
    logic [31:0] wdata = 32'd0, badv_in = 32'd0, pc = 32'd0;
    logic [5:0]  int_i = 6'd0;
    logic        flush, flush_im, int_req;
    logic [31:0] excaddr, data_o, status_o, cause_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] reg_pool [0:6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

    // Reference model state; Count is base plus half the cycles since it was last loaded.
    logic [31:0] m_status, m_epc, m_badv, m_base, m_compare;
    logic        m_bd, m_ti, m_ireq, m_fim;
    logic [4:0]  m_exc;
    logic [1:0]  m_swip;
    logic [5:0]  m_hwip;
    int unsigned m_cycles;

    cp0_unit dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .we(we), .re(re), .waddr(waddr), .raddr(raddr),
        .wdata(wdata), .int_i(int_i), .exccode_i(exccode), .exc_badvaddr_i(badv_in), .pc_i(pc),
        .in_delay_i(in_delay), .flush(flush), .flush_im(flush_im), .cp0_excaddr(excaddr),
        .data_o(data_o), .status_o(status_o), .cause_o(cause_o), .int_req_o(int_req)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_count();
        if (!TIMER_EN) return 32'd0;
        return m_base + 32'(m_cycles / 2);
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hwip[5] | m_ti, m_hwip[4:0], m_swip};
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = 32'd0;
        c[31] = m_bd;
        c[30] = m_ti;
        c[15:8] = m_ip();
        c[6:2] = m_exc;
        return c;
    endfunction

    function automatic logic [31:0] exp_data();
        if (!rst_n || !re) return 32'd0;
        case (raddr)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return TIMER_EN ? m_compare : 32'd0;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_excaddr();
        if (!rst_n || exccode == EXC_NONE) return 32'd0;
        if (exccode == EXC_INT) return 32'hBFC0_0400;
        if (exccode == EXC_ERET) return (we && waddr == 5'd14) ? wdata : m_epc;
        return 32'hBFC0_0380;
    endfunction

    // Advance the model by one edge using the current inputs, then wait for that edge.
    task automatic tick();
        logic [31:0] n_status, n_epc, n_badv, n_base, n_cmp;
        logic        n_bd, n_ti, n_ireq, n_fim, is_exc, mt;
        logic [4:0]  n_exc;
        logic [1:0]  n_swip;
        logic [5:0]  n_hwip;
        int unsigned n_cycles;
        n_status = m_status; n_epc = m_epc; n_badv = m_badv; n_base = m_base; n_cmp = m_compare;
        n_bd = m_bd; n_ti = m_ti; n_exc = m_exc; n_swip = m_swip; n_cycles = m_cycles;
        if (!rst_n) begin
            n_status = 32'h1000_0000; n_epc = 32'd0; n_badv = 32'd0; n_base = 32'd0; n_cmp = 32'd0;
            n_bd = 1'b0; n_ti = 1'b0; n_exc = 5'd0; n_swip = 2'd0; n_hwip = 6'd0; n_cycles = 0;
            n_ireq = 1'b0; n_fim = 1'b0;
        end else begin
            n_fim  = (exccode != EXC_NONE);
            n_ireq = m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'd0);
            n_hwip = int_i;
            is_exc = (exccode != EXC_NONE) && (exccode != EXC_ERET);
            mt     = we && (exccode == EXC_NONE);
            if (is_exc) begin
                if (!m_status[1]) begin
                    n_epc = in_delay ? pc - 32'd4 : pc;
                    n_bd  = in_delay;
                end
                n_status[1] = 1'b1;
                n_exc = exccode;
                n_badv = badv_in;
            end else if (exccode == EXC_ERET) begin
                n_status[1] = 1'b0;
            end else if (mt && waddr == 5'd12) begin
                n_status = wdata & 32'h1000_FF03;
            end else if (mt && waddr == 5'd13) begin
                n_swip = wdata[9:8];
            end else if (mt && waddr == 5'd14) begin
                n_epc = wdata;
            end
            if (TIMER_EN) begin
                if (mt && waddr == 5'd9) begin
                    n_base = wdata;
                    n_cycles = 0;
                end else begin
                    n_cycles = m_cycles + 1;
                    if ((n_cycles % 2) == 0 && (n_base + 32'(n_cycles / 2)) == m_compare) n_ti = 1'b1;
                end
                if (mt && waddr == 5'd11) begin
                    n_cmp = wdata;
                    n_ti = 1'b0;
                end
            end
        end
        @(posedge clk);
        m_status = n_status; m_epc = n_epc; m_badv = n_badv; m_base = n_base; m_compare = n_cmp;
        m_bd = n_bd; m_ti = n_ti; m_exc = n_exc; m_swip = n_swip; m_hwip = n_hwip; m_cycles = n_cycles;
        m_ireq = n_ireq; m_fim = n_fim;
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; exccode = EXC_NONE; in_delay = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
        idle_inputs();
        we = 1'b1; waddr = a; wdata = v;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; re = 1'b1; raddr = 5'd12; exccode = 5'h04; we = 1'b1; waddr = 5'd14;
        #2;
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b expected 0", flush); end
        n_checks++; if (excaddr !== 32'd0) begin n_fail++; $display("FAIL rst_excaddr: got %h expected 0", excaddr); end
        n_checks++; if (data_o !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", data_o); end
        tick();
        tick();
        n_checks++; if (status_o !== 32'h1000_0000) begin n_fail++; $display("FAIL rst_status: got %h expected 10000000", status_o); end
        n_checks++; if (cause_o !== 32'd0) begin n_fail++; $display("FAIL rst_cause: got %h expected 0", cause_o); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL rst_intreq: got %b expected 0", int_req); end
        n_checks++; if (flush_im !== 1'b0) begin n_fail++; $display("FAIL rst_flush_im: got %b expected 0", flush_im); end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_exception();
        idle_inputs();
        exccode = 5'h04; pc = 32'h8000_0010; in_delay = 1'b1; badv_in = 32'h0000_1234;
        #2;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL exc_flush: got %b expected 1", flush); end
        n_checks++; if (excaddr !== 32'hBFC0_0380) begin n_fail++; $display("FAIL exc_addr: got %h expected bfc00380", excaddr); end
        tick();
        idle_inputs();
        re = 1'b1; raddr = 5'd14;
        #2;
        n_checks++; if (data_o !== 32'h8000_000C) begin n_fail++; $display("FAIL exc_epc: got %h expected 8000000c", data_o); end
        n_checks++; if (cause_o[31] !== 1'b1) begin n_fail++; $display("FAIL exc_bd: got %b expected 1", cause_o[31]); end
        n_checks++; if (cause_o[6:2] !== 5'h04) begin n_fail++; $display("FAIL exc_code: got %h expected 04", cause_o[6:2]); end
        n_checks++; if (status_o[1] !== 1'b1) begin n_fail++; $display("FAIL exc_exl: got %b expected 1", status_o[1]); end
        n_checks++; if (flush_im !== 1'b1) begin n_fail++; $display("FAIL exc_flush_im: got %b expected 1", flush_im); end
        raddr = 5'd8;
        #1;
        n_checks++; if (data_o !== 32'h0000_1234) begin n_fail++; $display("FAIL exc_badv: got %h expected 00001234", data_o); end
        tick();
    endtask

    task automatic test_nested();
        idle_inputs();
        exccode = 5'h05; pc = 32'h8000_0100; in_delay = 1'b0;
        tick();
        idle_inputs();
        re = 1'b1; raddr = 5'd14;
        #2;
        n_checks++; if (data_o !== 32'h8000_000C) begin n_fail++; $display("FAIL nest_epc: got %h expected 8000000c", data_o); end
        n_checks++; if (cause_o[6:2] !== 5'h05) begin n_fail++; $display("FAIL nest_code: got %h expected 05", cause_o[6:2]); end
        n_checks++; if (cause_o[31] !== 1'b1) begin n_fail++; $display("FAIL nest_bd: got %b expected 1", cause_o[31]); end
        tick();
    endtask

    task automatic test_eret_bypass();
        idle_inputs();
        exccode = EXC_ERET; we = 1'b1; waddr = 5'd14; wdata = 32'h8000_0200;
        #2;
        n_checks++; if (excaddr !== 32'h8000_0200) begin n_fail++; $display("FAIL eret_bypass: got %h expected 80000200", excaddr); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL eret_flush: got %b expected 1", flush); end
        tick();
        idle_inputs();
        re = 1'b1; raddr = 5'd14;
        #2;
        n_checks++; if (status_o[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b expected 0", status_o[1]); end
        n_checks++; if (data_o !== 32'h8000_000C) begin n_fail++; $display("FAIL eret_epc_kept: got %h expected 8000000c", data_o); end
        exccode = EXC_ERET; re = 1'b0;
        #1;
        n_checks++; if (excaddr !== 32'h8000_000C) begin n_fail++; $display("FAIL eret_addr: got %h expected 8000000c", excaddr); end
        tick();
    endtask

    task automatic test_hw_int();
        mtc0(5'd12, 32'h1000_0401);
        int_i = 6'b000001;
        tick();
        n_checks++; if (cause_o[10] !== 1'b1) begin n_fail++; $display("FAIL hw_ip: got %b expected 1", cause_o[10]); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL hw_req_early: got %b expected 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL hw_req: got %b expected 1", int_req); end
        mtc0(5'd12, 32'h1000_0403);
        tick();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL hw_req_exl: got %b expected 0", int_req); end
        exccode = EXC_INT;
        #2;
        n_checks++; if (excaddr !== 32'hBFC0_0400) begin n_fail++; $display("FAIL int_vector: got %h expected bfc00400", excaddr); end
        tick();
        idle_inputs();
        int_i = 6'd0;
        tick();
    endtask

    task automatic test_mtc0_masks();
        mtc0(5'd12, 32'hFFFF_FFFF);
        n_checks++; if (status_o !== 32'h1000_FF03) begin n_fail++; $display("FAIL status_mask: got %h expected 1000ff03", status_o); end
        we = 1'b1; waddr = 5'd12; wdata = 32'h1000_0000; re = 1'b1; raddr = 5'd12;
        #2;
        n_checks++; if (data_o !== 32'h1000_FF03) begin n_fail++; $display("FAIL read_prewrite: got %h expected 1000ff03", data_o); end
        tick();
        n_checks++; if (status_o !== 32'h1000_0000) begin n_fail++; $display("FAIL status_write: got %h expected 10000000", status_o); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        n_checks++; if (cause_o[9:8] !== 2'b11) begin n_fail++; $display("FAIL cause_swip: got %b expected 11", cause_o[9:8]); end
        n_checks++; if (cause_o[29:16] !== 14'd0 || cause_o[7] !== 1'b0) begin n_fail++; $display("FAIL cause_mask: got %h", cause_o); end
        mtc0(5'd8, 32'hDEAD_BEEF);
        re = 1'b1; raddr = 5'd8;
        #2;
        n_checks++; if (data_o !== m_badv) begin n_fail++; $display("FAIL badv_ro: got %h expected %h", data_o, m_badv); end
        mtc0(5'd13, 32'd0);
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        mtc0(5'd12, 32'h1000_8001);
        mtc0(5'd9, 32'h0000_0100);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (cause_o[30] !== (k == 10)) begin n_fail++; $display("FAIL ti_edge%0d: got %b expected %b", k, cause_o[30], k == 10); end
        end
        re = 1'b1; raddr = 5'd9;
        #2;
        n_checks++; if (data_o !== 32'd5) begin n_fail++; $display("FAIL count5: got %h expected 5", data_o); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL ti_req_early: got %b expected 0", int_req); end
        tick();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL ti_req: got %b expected 1", int_req); end
        mtc0(5'd11, 32'h0000_0100);
        n_checks++; if (cause_o[30] !== 1'b0) begin n_fail++; $display("FAIL ti_clear: got %b expected 0", cause_o[30]); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        tick();
        re = 1'b1; raddr = 5'd9;
        #2;
        n_checks++; if (data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL count_hold: got %h expected ffffffff", data_o); end
        tick();
        n_checks++; if (data_o !== 32'd0) begin n_fail++; $display("FAIL count_wrap: got %h expected 0", data_o); end
        mtc0(5'd11, 32'd2);
        mtc0(5'd9, 32'd0);
        for (int k = 0; k < 4; k++) tick();
    endtask
`else
    task automatic test_timer();
        mtc0(5'd9, 32'd123);
        mtc0(5'd11, 32'd77);
        re = 1'b1; raddr = 5'd9;
        #2;
        n_checks++; if (data_o !== 32'd0) begin n_fail++; $display("FAIL count_off: got %h expected 0", data_o); end
        raddr = 5'd11;
        #1;
        n_checks++; if (data_o !== 32'd0) begin n_fail++; $display("FAIL compare_off: got %h expected 0", data_o); end
        n_checks++; if (cause_o[30] !== 1'b0) begin n_fail++; $display("FAIL ti_off: got %b expected 0", cause_o[30]); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        idle_inputs();
        if (TIMER_EN) begin
            n_checks++; if (cause_o[30] !== 1'b1) begin n_fail++; $display("FAIL mid_ti_pre: got %b expected 1", cause_o[30]); end
        end
        exccode = 5'h0C; int_i = 6'b100001;
        tick();
        n_checks++; if (status_o[1] !== 1'b1) begin n_fail++; $display("FAIL mid_exl_pre: got %b expected 1", status_o[1]); end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        n_checks++; if (status_o !== 32'h1000_0000) begin n_fail++; $display("FAIL mid_status: got %h expected 10000000", status_o); end
        n_checks++; if (cause_o !== 32'd0) begin n_fail++; $display("FAIL mid_cause: got %h expected 0", cause_o); end
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mid_intreq: got %b expected 0", int_req); end
        n_checks++; if (flush_im !== 1'b0) begin n_fail++; $display("FAIL mid_flush_im: got %b expected 0", flush_im); end
        rst_n = 1'b1; int_i = 6'd0; re = 1'b1; raddr = 5'd9;
        #2;
        n_checks++; if (data_o !== 32'd0) begin n_fail++; $display("FAIL mid_count: got %h expected 0", data_o); end
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 1);
            waddr = reg_pool[$urandom_range(0, 6)];
            raddr = reg_pool[$urandom_range(0, 6)];
            wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            case ($urandom_range(0, 9))
                0:       exccode = EXC_INT;
                1:       exccode = 5'h04;
                2:       exccode = EXC_ERET;
                3:       exccode = 5'h0C;
                default: exccode = EXC_NONE;
            endcase
            badv_in = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            in_delay = ($urandom_range(0, 1) == 1);
            #2;
            n_checks++; if (flush !== (rst_n && exccode != EXC_NONE)) begin n_fail++; $display("FAIL rnd_flush it%0d: got %b", it, flush); end
            n_checks++; if (excaddr !== exp_excaddr()) begin n_fail++; $display("FAIL rnd_excaddr it%0d: got %h expected %h", it, excaddr, exp_excaddr()); end
            n_checks++; if (data_o !== exp_data()) begin n_fail++; $display("FAIL rnd_data it%0d: got %h expected %h", it, data_o, exp_data()); end
            tick();
            n_checks++; if (status_o !== m_status) begin n_fail++; $display("FAIL rnd_status it%0d: got %h expected %h", it, status_o, m_status); end
            n_checks++; if (cause_o !== m_cause()) begin n_fail++; $display("FAIL rnd_cause it%0d: got %h expected %h", it, cause_o, m_cause()); end
            n_checks++; if (int_req !== m_ireq) begin n_fail++; $display("FAIL rnd_intreq it%0d: got %b expected %b", it, int_req, m_ireq); end
            n_checks++; if (flush_im !== m_fim) begin n_fail++; $display("FAIL rnd_flush_im it%0d: got %b expected %b", it, flush_im, m_fim); end
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_nested();
        test_eret_bypass();
        test_hw_int();
        test_mtc0_masks();
        test_timer();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
